dft_sample_frame_buffer: RTL and testbench

//   Ping-pong frame buffer directly upstream of the DFT stage. Captures ADC

---
 rtl/dft_pkg.sv | 15 +
 rtl/dft_sample_frame_buffer_if.sv | 33 +++
 rtl/dft_sample_ram.sv | 54 +++++
 rtl/dft_sample_frame_buffer.sv | 167 ++++++++++++++++
 tb/tb_dft_sample_frame_buffer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dft_pkg.sv
// Shared definitions for the DFT sample path: frame geometry and the
// read-FSM state encoding used by the sample frame buffer.
package dft_pkg;

  localparam int N_SAMPLES = 1000;  // samples per frame (DFT length)
  localparam int SAMPLE_W  = 11;    // sample width, bits
  localparam int ADDR_W    = 10;    // bank address width, 2**ADDR_W >= N_SAMPLES

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_VALID = 2'd2
  } rd_state_e;

endpackage

// File: rtl/dft_sample_frame_buffer_if.sv
// Sample-in / frame-out bus of the DFT sample frame buffer.
//   sample_in/sample_valid         ADC sample stream into the buffer
//   out_sample/out_index/out_last  frame sample stream towards the DFT
//   out_valid/out_ready            valid/ready handshake of the output stream
//   frame_ready                    a complete bank is waiting or streaming
//   overflow                       sticky sample-drop flag
// master = sample source / DFT side, slave = frame buffer.
interface dft_sample_frame_buffer_if #(
  parameter int SAMPLE_W = dft_pkg::SAMPLE_W,
  parameter int ADDR_W   = dft_pkg::ADDR_W
) ();

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] out_sample;
  logic [ADDR_W-1:0]   out_index;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;
  logic                frame_ready;
  logic                overflow;

  modport master (
    output sample_in, sample_valid, out_ready,
    input  out_sample, out_index, out_valid, out_last, frame_ready, overflow
  );

  modport slave (
    input  sample_in, sample_valid, out_ready,
    output out_sample, out_index, out_valid, out_last, frame_ready, overflow
  );

endinterface

// File: rtl/dft_sample_ram.sv
// Two-bank sample store: simple dual-port RAM, one write port and one
// registered read port, depth 2*N_SAMPLES. Bank 1 sits at offset N_SAMPLES.
//   clk, rst                       clock, async active-high reset (read reg only)
//   wr_en_i/wr_bank_i/wr_addr_i    write strobe and {bank, addr} location
//   wr_data_i                      sample to store
//   rd_en_i/rd_bank_i/rd_addr_i    read strobe and {bank, addr} location
//   rd_data_o                      read data, valid the cycle after rd_en_i
module dft_sample_ram #(
  parameter int N_SAMPLES = dft_pkg::N_SAMPLES,
  parameter int SAMPLE_W  = dft_pkg::SAMPLE_W,
  parameter int ADDR_W    = dft_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic                wr_bank_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  input  logic                rd_en_i,
  input  logic                rd_bank_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [SAMPLE_W-1:0] rd_data_o
);

  localparam int DEPTH  = 2 * N_SAMPLES;
  localparam int RAM_AW = $clog2(DEPTH);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] rd_data_q;
  logic [RAM_AW-1:0]   wr_idx;
  logic [RAM_AW-1:0]   rd_idx;

  assign wr_idx = RAM_AW'(wr_bank_i ? (32'(N_SAMPLES) + 32'(wr_addr_i)) : 32'(wr_addr_i));
  assign rd_idx = RAM_AW'(rd_bank_i ? (32'(N_SAMPLES) + 32'(rd_addr_i)) : 32'(rd_addr_i));

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx] <= wr_data_i;
    end
  end

  // The read register doubles as the output sample register of the buffer,
  // so it is reset and only loads when a fetch is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dft_sample_frame_buffer.sv
// Ping-pong frame buffer in front of the DFT. ADC samples fill one bank
// while the other, completed bank streams out oldest frame first over a
// valid/ready handshake. Samples arriving with both banks full are dropped
// and flagged through the sticky overflow output.
//   clk   clock, rising edge
//   rst   asynchronous reset, active-high
//   ena   global enable, 0 freezes every register
//   bus   sample input / frame output bus (slave side)
//
// Read FSM
//   state   | meaning
//   R_IDLE  | waiting for bank rd_bank to be full
//   R_FETCH | RAM read of rd_addr in flight
//   R_VALID | sample presented, waiting for out_ready
module dft_sample_frame_buffer #(
  parameter int N_SAMPLES = dft_pkg::N_SAMPLES,
  parameter int SAMPLE_W  = dft_pkg::SAMPLE_W,
  parameter int ADDR_W    = dft_pkg::ADDR_W
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     ena,
  dft_sample_frame_buffer_if.slave bus
);

  import dft_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  rd_state_e         state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_ready_q, frame_ready_d;
  logic              overflow_q, overflow_d;

  logic              wr_en;
  logic              wr_done;
  logic              rel_bank;
  logic              rd_en;
  logic [SAMPLE_W-1:0] rd_data;

  // Write side and bank bookkeeping
  always_comb begin
    wr_en    = ena & bus.sample_valid & ~full_q[wr_bank_q];
    wr_done  = wr_en & (wr_addr_q == LAST_ADDR);
    rel_bank = (state_q == R_VALID) & bus.out_ready & out_last_q;

    full_d = full_q;
    if (rel_bank) full_d[rd_bank_q] = 1'b0;
    if (wr_done)  full_d[wr_bank_q] = 1'b1;

    wr_addr_d = wr_addr_q;
    if (wr_en) begin
      wr_addr_d = wr_done ? '0 : wr_addr_q + ADDR_W'(1);
    end

    // Move off a full bank as soon as the other one is (or becomes) free.
    // This covers a frame completing while the other bank is released in
    // the same cycle, and a bank parked full until its peer drains.
    wr_bank_d = wr_bank_q;
    if (full_d[wr_bank_q] && !full_d[~wr_bank_q]) begin
      wr_bank_d = ~wr_bank_q;
    end

    overflow_d    = overflow_q | (bus.sample_valid & full_q[wr_bank_q]);
    frame_ready_d = |full_d;
  end

  // Read FSM next state and output registers
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_bank_d   = rd_bank_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    rd_en       = 1'b0;

    unique case (state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_addr_d = '0;
          state_d   = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_en       = ena;
        out_index_d = rd_addr_q;
        out_last_d  = (rd_addr_q == LAST_ADDR);
        out_valid_d = 1'b1;
        state_d     = R_VALID;
      end
      R_VALID: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            rd_bank_d = ~rd_bank_q;
            state_d   = R_IDLE;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            state_d   = R_FETCH;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= R_IDLE;
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      out_index_q   <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else if (ena) begin
      state_q       <= state_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      out_index_q   <= out_index_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_ready_q <= frame_ready_d;
      overflow_q    <= overflow_d;
    end
  end

  dft_sample_ram #(
    .N_SAMPLES (N_SAMPLES),
    .SAMPLE_W  (SAMPLE_W),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_addr_q),
    .wr_data_i (bus.sample_in),
    .rd_en_i   (rd_en),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (rd_data)
  );

  assign bus.out_sample  = rd_data;
  assign bus.out_index   = out_index_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_dft_sample_frame_buffer.sv
module tb_dft_sample_frame_buffer;

  localparam int NT = 4;
  localparam int SW = 11;
  localparam int NR = 1000;

  logic clk = 1'b0;
  logic rst, rst2, ena;
  always #5 clk = ~clk;

  dft_sample_frame_buffer_if #(.SAMPLE_W(SW), .ADDR_W(2))  bus  ();
  dft_sample_frame_buffer_if #(.SAMPLE_W(SW), .ADDR_W(10)) bus2 ();

  dft_sample_frame_buffer #(.N_SAMPLES(NT), .SAMPLE_W(SW), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .bus(bus));

  dft_sample_frame_buffer #(.N_SAMPLES(NR), .SAMPLE_W(SW), .ADDR_W(10)) dut2 (
    .clk(clk), .rst(rst2), .ena(1'b1), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame queues + latency) ----------
  int fq[$];   // completed frames, concatenated, oldest first
  int cur[$];  // frame under assembly
  int pos, need;
  bit m_valid, m_last, m_fr, m_ovf, room;
  int m_sample, m_index;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete(); cur.delete();
      pos = 0; need = 2;
      m_valid = 0; m_last = 0; m_sample = 0; m_index = 0; m_fr = 0; m_ovf = 0;
    end else if (ena) begin
      room = (fq.size() < 2*NT);
      if (bus.sample_valid && !room) m_ovf = 1;
      if (m_valid && bus.out_ready) begin
        m_valid = 0;
        pos++;
        if (pos == NT) begin
          repeat (NT) void'(fq.pop_front());
          pos = 0;
          need = 2;
        end else begin
          need = 1;
        end
      end else if (!m_valid && fq.size() > 0) begin
        need--;
        if (need == 0) begin
          m_valid = 1; m_sample = fq[pos]; m_index = pos; m_last = (pos == NT-1);
        end
      end
      if (bus.sample_valid && room) begin
        cur.push_back(int'(bus.sample_in));
        if (cur.size() == NT) begin
          foreach (cur[i]) fq.push_back(cur[i]);
          cur.delete();
        end
      end
      m_fr = (fq.size() > 0);
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("out_valid", int'(bus.out_valid), int'(m_valid));
      chk("frame_ready", int'(bus.frame_ready), int'(m_fr));
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      if (m_valid) begin
        chk("out_sample", int'(bus.out_sample), m_sample);
        chk("out_index", int'(bus.out_index), m_index);
        chk("out_last", int'(bus.out_last), int'(m_last));
      end
    end
  end

  // ---------------- handshake log ----------------
  int got_s[$], got_i[$], got_l[$];
  always @(posedge clk) begin
    if (rst === 1'b0 && ena && bus.out_valid && bus.out_ready) begin
      got_s.push_back(int'(bus.out_sample));
      got_i.push_back(int'(bus.out_index));
      got_l.push_back(int'(bus.out_last));
    end
  end

  // ---------------- N=1000 ramp checker ----------------
  int ramp_exp = 0;
  always @(negedge clk) begin
    if (rst2 === 1'b0 && bus2.out_valid && bus2.out_ready) begin
      chk("ramp_index", int'(bus2.out_index), ramp_exp);
      chk("ramp_sample", int'(bus2.out_sample), ramp_exp);
      chk("ramp_last", int'(bus2.out_last), int'(ramp_exp == NR-1));
      ramp_exp++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_s.delete(); got_i.delete(); got_l.delete();
  endtask

  task automatic wr(input int v);
    bus.sample_in = SW'(v);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_hs(input string nm, input int n, input int budget);
    for (int c = 0; c < budget && got_s.size() < n; c++) tick();
    chk(nm, got_s.size(), n);
  endtask

  task automatic check_seq(input string nm, input int off, input int base, input int step, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      if (off + k < got_s.size()) begin
        chk({nm, "_sample"}, got_s[off+k], base + step*k);
        chk({nm, "_index"}, got_i[off+k], k % NT);
        chk({nm, "_last"}, got_l[off+k], int'((k % NT) == NT-1));
      end else begin
        chk({nm, "_missing"}, got_s.size(), off + k + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0; ena = 1'b1;
    bus.sample_in = '0; bus.sample_valid = 1'b0; bus.out_ready = 1'b0;
    bus2.sample_in = '0; bus2.sample_valid = 1'b0; bus2.out_ready = 1'b0;
    #2 rst = 1'b1; rst2 = 1'b1;
    tick(); tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_out_sample", int'(bus.out_sample), 0);
    chk("rst_out_index", int'(bus.out_index), 0);
    chk("rst_frame_ready", int'(bus.frame_ready), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    rst = 1'b0; rst2 = 1'b0;
    tick();

    // 1: basic frame, first valid two cycles after the frame completes
    clear_log();
    bus.out_ready = 1'b1;
    wr(10); wr(20); wr(30); wr(40);
    chk("t1_frame_ready", int'(bus.frame_ready), 1);
    chk("t1_valid_w0", int'(bus.out_valid), 0);
    tick();
    chk("t1_valid_w1", int'(bus.out_valid), 0);
    tick();
    chk("t1_valid_w2", int'(bus.out_valid), 1);
    chk("t1_first_sample", int'(bus.out_sample), 10);
    chk("t1_first_index", int'(bus.out_index), 0);
    wait_hs("t1_hs", 4, 40);
    check_seq("t1", 0, 10, 10, 4);
    tick();
    chk("t1_frame_ready_end", int'(bus.frame_ready), 0);

    // 2: back-pressure mid-frame
    clear_log();
    bus.out_ready = 1'b0;
    wr(1); wr(2); wr(3); wr(4);
    bus.out_ready = 1'b1;
    wait_hs("t2_hs2", 2, 40);
    bus.out_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t2_hold_valid", int'(bus.out_valid), 1);
      chk("t2_hold_index", int'(bus.out_index), 2);
      chk("t2_hold_sample", int'(bus.out_sample), 3);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_hs("t2_hs", 4, 40);
    check_seq("t2", 0, 1, 1, 4);

    // 3: both banks full, remaining samples dropped
    clear_log();
    bus.out_ready = 1'b0;
    for (int v = 100; v < 112; v++) begin
      bus.sample_in = SW'(v);
      bus.sample_valid = 1'b1;
      tick();
    end
    bus.sample_valid = 1'b0;
    chk("t3_overflow", int'(bus.overflow), 1);
    chk("t3_frame_ready", int'(bus.frame_ready), 1);
    tick(); tick(); tick();
    chk("t3_overflow_sticky", int'(bus.overflow), 1);
    bus.out_ready = 1'b1;
    wait_hs("t3_hs", 8, 80);
    check_seq("t3", 0, 100, 1, 8);
    chk("t3_frame_ready_end", int'(bus.frame_ready), 0);
    chk("t3_overflow_end", int'(bus.overflow), 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_overflow", int'(bus.overflow), 0);

    // 4: last handshake of one bank coincides with completion of the other
    clear_log();
    bus.out_ready = 1'b0;
    for (int v = 200; v < 204; v++) wr(v);
    for (int v = 210; v < 214; v++) wr(v);
    bus.out_ready = 1'b1;
    wait_hs("t4_hsA", 4, 40);
    bus.out_ready = 1'b0;
    for (int v = 220; v < 223; v++) wr(v);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && !(bus.out_valid && bus.out_last); c++) tick();
    chk("t4_last_pending", int'(bus.out_valid && bus.out_last), 1);
    wr(223);
    chk("t4_overflow", int'(bus.overflow), 0);
    chk("t4_frame_ready", int'(bus.frame_ready), 1);
    for (int v = 230; v < 234; v++) wr(v);
    wait_hs("t4_hs", 16, 120);
    check_seq("t4A", 0, 200, 1, 4);
    check_seq("t4B", 4, 210, 1, 4);
    check_seq("t4C", 8, 220, 1, 4);
    check_seq("t4D", 12, 230, 1, 4);
    chk("t4_overflow_end", int'(bus.overflow), 0);

    // 5: asynchronous reset mid-stream
    clear_log();
    bus.out_ready = 1'b1;
    for (int v = 300; v < 304; v++) wr(v);
    wait_hs("t5_pre", 2, 40);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", int'(bus.out_valid), 0);
    chk("t5_sample", int'(bus.out_sample), 0);
    chk("t5_index", int'(bus.out_index), 0);
    chk("t5_last", int'(bus.out_last), 0);
    chk("t5_frame_ready", int'(bus.frame_ready), 0);
    tick();
    rst = 1'b0;
    clear_log();
    for (int v = 50; v < 54; v++) wr(v);
    wait_hs("t5_hs", 4, 40);
    check_seq("t5", 0, 50, 1, 4);

    // 6: ena low freezes writes and handshakes
    clear_log();
    bus.out_ready = 1'b0;
    for (int v = 60; v < 64; v++) wr(v);
    tick(); tick();
    chk("t6_valid", int'(bus.out_valid), 1);
    wr(70); wr(71);
    ena = 1'b0;
    bus.sample_in = SW'(99);
    bus.sample_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t6_frz_valid", int'(bus.out_valid), 1);
    chk("t6_frz_index", int'(bus.out_index), 0);
    chk("t6_frz_sample", int'(bus.out_sample), 60);
    chk("t6_frz_hs", got_s.size(), 0);
    bus.sample_valid = 1'b0;
    ena = 1'b1;
    wr(72); wr(73);
    wait_hs("t6_hs", 8, 80);
    check_seq("t6a", 0, 60, 1, 4);
    check_seq("t6b", 4, 70, 1, 4);
    chk("t6_overflow", int'(bus.overflow), 0);

    // N=1000 ramp on the second instance
    bus2.out_ready = 1'b1;
    for (int v = 0; v < NR; v++) begin
      bus2.sample_in = SW'(v);
      bus2.sample_valid = 1'b1;
      tick();
    end
    bus2.sample_valid = 1'b0;
    for (int c = 0; c < 3000 && ramp_exp < NR; c++) tick();
    chk("ramp_count", ramp_exp, NR);
    chk("ramp_overflow", int'(bus2.overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
